button_debouncer: RTL

Conditions one raw, active-low push-button into clean, single-clock event strobes for the counter and LED logic. It synchronises the button into the clock domain, debounces press and release, and emits a one-cycle press strobe and a one-cycle release strobe. Holding the button produces auto-repeat strobes. It sits between the board button pin and any event-consuming block, such as the LED counter, which then counts on `press_pulse | repeat_pulse` instead of using the button as a clock.

---
 rtl/button_pkg.sv | 35 +++
 rtl/sync_2ff.sv | 34 +++
 rtl/button_debouncer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/button_pkg.sv
// ============================================================================
// Module      : button_pkg
// Description : Shared states, 12 MHz timing defaults and counter sizing.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package button_pkg;

    typedef enum logic [2:0] {
        RELEASED     = 3'd0,
        PRESS_WAIT   = 3'd1,
        PRESSED      = 3'd2,
        REPEAT       = 3'd3,
        RELEASE_WAIT = 3'd4
    } btn_state_t;

    localparam int unsigned c_DEBOUNCE_CYCLES_12MHZ = 240000;   // 20 ms
    localparam int unsigned c_HOLD_CYCLES_12MHZ     = 6000000;  // 500 ms
    localparam int unsigned c_REPEAT_CYCLES_12MHZ   = 1200000;  // 100 ms

    // Width able to hold 0 .. max-1 of the three timing limits.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchroniser for asynchronous board inputs.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/button_debouncer.sv
// ============================================================================
// Module      : button_debouncer
// Description : Debounces an active-low button into level, press, release
//               and auto-repeat strobes.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module button_debouncer
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_12MHZ,
    parameter int unsigned HOLD_CYCLES     = c_HOLD_CYCLES_12MHZ,
    parameter int unsigned REPEAT_CYCLES   = c_REPEAT_CYCLES_12MHZ
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int unsigned c_CNT_W = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DEB_LAST  = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_REP_LAST  = c_CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    logic               w_sync_q;
    logic               w_btn_s;
    btn_state_t         r_state;
    btn_state_t         w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_next_cnt;
    logic               w_level;
    logic               w_press;
    logic               w_release;
    logic               w_repeat;
    logic               r_level;
    logic               r_press;
    logic               r_release;
    logic               r_repeat;

    // Resets to the released level so reset never fakes a press.
    sync_2ff #(
        .RESET_VALUE (1'b1)
    ) u_btn_sync (
        .i_clk   (clk_in),
        .i_rst_n (rst_in),
        .i_d     (btn_in),
        .o_q     (w_sync_q)
    );

    assign w_btn_s = ~w_sync_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state   <= RELEASED;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_next_cnt;
            r_level   <= w_level;
            r_press   <= w_press;
            r_release <= w_release;
            r_repeat  <= w_repeat;
        end
    end

    // One counter serves debounce, hold and repeat; every exit clears it.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt + c_CNT_ONE;
        case (r_state)
            RELEASED: begin
                w_next_cnt = '0;
                if (w_btn_s) w_next_state = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!w_btn_s) begin
                    w_next_state = RELEASED;
                    w_next_cnt   = '0;
                end else if (r_cnt == c_DEB_LAST) begin
                    w_next_state = PRESSED;
                    w_next_cnt   = '0;
                end
            end
            PRESSED: begin
                if (!w_btn_s) begin
                    w_next_state = RELEASE_WAIT;
                    w_next_cnt   = '0;
                end else if (r_cnt == c_HOLD_LAST) begin
                    w_next_state = REPEAT;
                    w_next_cnt   = '0;
                end
            end
            REPEAT: begin
                if (!w_btn_s) begin
                    w_next_state = RELEASE_WAIT;
                    w_next_cnt   = '0;
                end else if (r_cnt == c_REP_LAST) begin
                    w_next_cnt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (w_btn_s) begin
                    w_next_state = PRESSED;
                    w_next_cnt   = '0;
                end else if (r_cnt == c_DEB_LAST) begin
                    w_next_state = RELEASED;
                    w_next_cnt   = '0;
                end
            end
            default: begin
                w_next_state = RELEASED;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_comb begin
        w_press   = (r_state == PRESS_WAIT) && w_btn_s && (r_cnt == c_DEB_LAST);
        w_release = (r_state == RELEASE_WAIT) && !w_btn_s && (r_cnt == c_DEB_LAST);
        w_repeat  = w_btn_s &&
                    (((r_state == PRESSED) && (r_cnt == c_HOLD_LAST)) ||
                     ((r_state == REPEAT)  && (r_cnt == c_REP_LAST)));
        w_level   = (w_next_state == PRESSED) ||
                    (w_next_state == REPEAT)  ||
                    (w_next_state == RELEASE_WAIT);
    end

    assign btn_level     = r_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign repeat_pulse  = r_repeat;

endmodule

`default_nettype wire
